// File: rtl/dm_pkg.sv
// Shared constants and colour codes for the 8x8 dot-matrix display path.
package dm_pkg;

   localparam int DM_ROWS = 8;
   localparam int DM_COLS = 8;
   localparam int DM_IDX_BITS = $clog2(DM_ROWS);

   typedef enum logic [1:0] {
      COLOUR_OFF    = 2'b00,
      COLOUR_GREEN  = 2'b01,
      COLOUR_RED    = 2'b10,
      COLOUR_YELLOW = 2'b11
   } colour_t;

   function automatic logic [DM_ROWS-1:0] row_onehot(input logic [DM_IDX_BITS-1:0] idx);
      logic [DM_ROWS-1:0] r;
      r = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/dot_matrix_scanner_scan_timer.sv
// Free-running prescaler that paces the row scan and supplies the PWM phase.
module scan_timer #(
   parameter int SCAN_DIV = 12,
   parameter int PWM_BITS = 3
) (
   input  logic                clk,
   input  logic                reset,
   output logic                scan_tick,
   output logic [PWM_BITS-1:0] pwm_phase
);

   logic [SCAN_DIV-1:0] prescaler;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         prescaler <= '0;
      else
         prescaler <= prescaler + 1'b1;
   end

   // The top bits sweep every PWM level exactly once per row period
   assign scan_tick = &prescaler;
   assign pwm_phase = prescaler[SCAN_DIV-1 -: PWM_BITS];

endmodule

// File: rtl/dot_matrix_scanner.sv
// 8x8 LED matrix scanner: double-buffered frame input, row scan, colour/PWM/blank gating.
module dot_matrix_scanner
   import dm_pkg::*;
#(
   parameter int SCAN_DIV = 12,
   parameter int PWM_BITS = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        frame_valid,
   output logic                        frame_ready,
   input  logic [DM_ROWS*DM_COLS-1:0]  frame_data,
   input  logic [1:0]                  colour,
   input  logic [PWM_BITS-1:0]         brightness,
   input  logic                        blank,
   output logic [DM_ROWS-1:0]          row,
   output logic [DM_COLS-1:0]          column_green,
   output logic [DM_COLS-1:0]          column_red,
   output logic                        frame_done
);

   logic                       scan_tick;
   logic [PWM_BITS-1:0]        pwm_phase;
   logic [DM_IDX_BITS-1:0]     idx;
   logic [DM_IDX_BITS-1:0]     next_idx;
   logic [DM_ROWS*DM_COLS-1:0] active;
   logic [DM_ROWS*DM_COLS-1:0] shadow;
   logic [DM_ROWS*DM_COLS-1:0] next_active;
   logic                       pending;
   logic                       wrap;
   logic                       pixel_on;
   logic                       green_en;
   logic                       red_en;
   logic [DM_COLS-1:0]         row_data;

   scan_timer #(
      .SCAN_DIV (SCAN_DIV),
      .PWM_BITS (PWM_BITS)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .scan_tick (scan_tick),
      .pwm_phase (pwm_phase)
   );

   // Columns are computed from the row and frame that become visible at this
   // edge, so a row change or frame swap never pairs a row with stale data.
   always_comb begin
      wrap        = scan_tick && (idx == DM_IDX_BITS'(DM_ROWS-1));
      next_idx    = scan_tick ? idx + 1'b1 : idx;
      next_active = (wrap && pending) ? shadow : active;
      row_data    = next_active[int'(next_idx)*DM_COLS +: DM_COLS];
      pixel_on    = !blank && (pwm_phase <= brightness);
      green_en    = (colour == COLOUR_GREEN) || (colour == COLOUR_YELLOW);
      red_en      = (colour == COLOUR_RED) || (colour == COLOUR_YELLOW);
   end

   assign frame_done = wrap;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx          <= '0;
         row          <= row_onehot('0);
         active       <= '0;
         shadow       <= '0;
         pending      <= 1'b0;
         frame_ready  <= 1'b1;
         column_green <= '0;
         column_red   <= '0;
      end else begin
         idx          <= next_idx;
         row          <= row_onehot(next_idx);
         active       <= next_active;
         column_green <= (pixel_on && green_en) ? row_data : '0;
         column_red   <= (pixel_on && red_en) ? row_data : '0;
         // Ready is low whenever a frame is pending, so accept and swap are exclusive
         if (frame_valid && frame_ready) begin
            shadow      <= frame_data;
            pending     <= 1'b1;
            frame_ready <= 1'b0;
         end else if (wrap && pending) begin
            pending     <= 1'b0;
            frame_ready <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Self-checking bench for dot_matrix_scanner against a cycle-count based display model.
module tb_dot_matrix_scanner;

   localparam int SCAN_DIV  = 4;
   localparam int PWM_BITS  = 2;
   localparam int ROW_CYC   = 1 << SCAN_DIV;
   localparam int FRAME_CYC = 8 * ROW_CYC;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        frame_valid = 1'b0;
   logic [63:0] frame_data = '0;
   logic [1:0]  colour = 2'b11;
   logic [PWM_BITS-1:0] brightness = '1;
   logic        blank = 1'b0;
   logic        frame_ready;
   logic [7:0]  row;
   logic [7:0]  column_green;
   logic [7:0]  column_red;
   logic        frame_done;

   dot_matrix_scanner #(
      .SCAN_DIV (SCAN_DIV),
      .PWM_BITS (PWM_BITS)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .frame_valid  (frame_valid),
      .frame_ready  (frame_ready),
      .frame_data   (frame_data),
      .colour       (colour),
      .brightness   (brightness),
      .blank        (blank),
      .row          (row),
      .column_green (column_green),
      .column_red   (column_red),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Model state: time since reset release, shown frame, buffered frame
   int          t;
   logic [63:0] disp;
   logic [63:0] shadow;
   bit          pending;
   bit          staged;
   logic [63:0] staged_data;
   bit          accepted;
   logic [7:0]  gate_green;
   logic [7:0]  gate_red;

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
      end
   endtask

   task automatic reset_model();
      t = 0;
      disp = '0;
      shadow = '0;
      pending = 0;
      staged = 0;
      accepted = 0;
      gate_green = '0;
      gate_red = '0;
   endtask

   // Check cycle t, note the effect of this cycle's inputs, advance one clock
   task automatic cycle();
      int  r;
      int  ph;
      bit  on;
      logic [7:0] pix;
      if (t % FRAME_CYC == 0 && t > 0 && pending) begin
         disp = shadow;
         pending = 0;
      end
      if (staged) begin
         shadow = staged_data;
         pending = 1;
         staged = 0;
      end
      r = (t / ROW_CYC) % 8;
      pix = disp[8*r +: 8];
      check8("row", row, 8'(1 << r));
      check8("frame_ready", {7'b0, frame_ready}, {7'b0, !pending});
      check8("frame_done", {7'b0, frame_done}, (t % FRAME_CYC == FRAME_CYC-1) ? 8'h01 : 8'h00);
      check8("column_green", column_green, pix & gate_green);
      check8("column_red", column_red, pix & gate_red);
      ph = (t % ROW_CYC) >> (SCAN_DIV - PWM_BITS);
      on = !blank && (ph <= int'(brightness));
      gate_green = (on && colour[0]) ? 8'hFF : 8'h00;
      gate_red   = (on && colour[1]) ? 8'hFF : 8'h00;
      accepted = frame_valid && !pending;
      if (accepted) begin
         staged = 1;
         staged_data = frame_data;
      end
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Hold a frame on the input until the model sees it taken, within a budget
   task automatic offer_held(input logic [63:0] data);
      int waited;
      waited = 0;
      frame_data = data;
      frame_valid = 1'b1;
      do begin
         cycle();
         waited++;
      end while (!accepted && waited < 3*FRAME_CYC);
      frame_valid = 1'b0;
      if (!accepted) check8("accept_timeout", 8'h00, 8'h01);
   endtask

   initial begin
      int on_cnt;
      int red_cnt;
      int waited;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      check8("rst_row", row, 8'h01);
      check8("rst_green", column_green, 8'h00);
      check8("rst_red", column_red, 8'h00);
      check8("rst_ready", {7'b0, frame_ready}, 8'h01);
      check8("rst_done", {7'b0, frame_done}, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      #1;

      // Idle scan with row 0 -> row 1 at cycle 16
      run(20);

      // Single frame with only row 0 lit, yellow at full brightness
      frame_data = 64'h0000_0000_0000_00A5;
      frame_valid = 1'b1;
      cycle();
      frame_valid = 1'b0;
      run(119);

      // Frame taken immediately, then a second one held while the first is pending
      offer_held({$urandom, $urandom});
      offer_held({$urandom, $urandom});
      run(20);

      // Random inputs, random frame offers
      for (int i = 0; i < 700; i++) begin
         colour = 2'($urandom_range(0, 3));
         brightness = PWM_BITS'($urandom_range(0, 3));
         blank = ($urandom_range(0, 3) == 0);
         frame_valid = ($urandom_range(0, 7) == 0);
         frame_data = {$urandom, $urandom};
         cycle();
      end
      frame_valid = 1'b0;

      // Green only at half duty on a fully lit frame: 8 of 16 cycles per row
      colour = 2'b01;
      brightness = PWM_BITS'(1);
      blank = 1'b0;
      offer_held(64'hFFFF_FFFF_FFFF_FFFF);
      waited = 0;
      while ((pending || staged || (t % ROW_CYC) != 0) && waited < 2*FRAME_CYC) begin
         cycle();
         waited++;
      end
      on_cnt = 0;
      red_cnt = 0;
      for (int i = 0; i < ROW_CYC; i++) begin
         if (column_green === 8'hFF) on_cnt++;
         if (column_red !== 8'h00) red_cnt++;
         cycle();
      end
      check8("pwm_on_cycles", 8'(on_cnt), 8'd8);
      check8("pwm_red_cycles", 8'(red_cnt), 8'd0);

      // Blanked frame, then colour off
      blank = 1'b1;
      colour = 2'b11;
      brightness = '1;
      run(FRAME_CYC);
      blank = 1'b0;
      colour = 2'b00;
      run(FRAME_CYC);
      colour = 2'b11;

      // Reset mid-frame with a frame pending
      offer_held({$urandom, $urandom});
      run(30);
      #2;
      reset = 1'b0;
      #1;
      check8("mid_rst_row", row, 8'h01);
      check8("mid_rst_green", column_green, 8'h00);
      check8("mid_rst_red", column_red, 8'h00);
      check8("mid_rst_ready", {7'b0, frame_ready}, 8'h01);
      check8("mid_rst_done", {7'b0, frame_done}, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      reset_model();
      #1;
      run(200);

      // Display recovers once a new frame is loaded
      offer_held({$urandom, $urandom});
      run(FRAME_CYC + 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
